// File: rtl/grng_pkg.sv
// Shared definitions for the Gaussian RNG generator and its sample buffer.
package grng_pkg;

  localparam int unsigned GRNG_FRAC_BITS   = 16;
  localparam int unsigned GRNG_GEN_LATENCY = 2;
  localparam int unsigned GRNG_WARMUP      = 5;

  // Q16.16 sample: integer part in [31:16], fraction in [15:0].
  typedef logic [31:0] grng_sample_t;

  typedef enum logic [0:0] {
    StWarmup,
    StRun
  } grng_buf_state_e;

  // Number of set bits; used to count requests still inside the generator.
  function automatic int unsigned grng_popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/grng_fifo.sv
// Synchronous FIFO with a registered head word and a synchronous clear.
module grng_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   head_valid,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             pop_ok;
  logic             empty_after;

  assign pop_ok      = pop && (count_q != '0);
  // FIFO has nothing left once this cycle's pop (if any) is taken.
  assign empty_after = (count_q == CW'(pop_ok));

  // Next pointers, count and head word; a push into an empty FIFO bypasses storage.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    head_d  = head_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      head_d  = '0;
    end else begin
      wptr_d  = wptr_q + AW'(push);
      rptr_d  = rptr_q + AW'(pop_ok);
      count_d = count_q + CW'(push) - CW'(pop_ok);
      if (push && empty_after) begin
        head_d = push_data;
      end else if (!empty_after) begin
        head_d = mem_q[rptr_d];
      end
    end
  end

  // Storage array; no reset needed since the head register masks stale slots.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      head_q  <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  assign head_valid = (count_q != '0);
  assign head_data  = head_q;
  assign count      = count_q;

endmodule

// File: rtl/grng_sample_buffer.sv
// Prefetch buffer between the CLT Gaussian generator and the exec-stage datapath.
module grng_sample_buffer
  import grng_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned GEN_LATENCY = GRNG_GEN_LATENCY,
  parameter int unsigned WARMUP      = GRNG_WARMUP
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  output logic                   gen_enable,
  input  logic [31:0]            gen_sample,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned WarmW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

  grng_buf_state_e        state_q, state_d;
  logic [WarmW-1:0]       warm_q, warm_d;
  logic [GEN_LATENCY-1:0] pipe_q, pipe_d;
  logic                   push;
  logic                   pop;
  int unsigned            inflight;
  int unsigned            occupancy;

  // A request leaving the end of the pipe captures gen_sample, unless flushed.
  assign push      = pipe_q[GEN_LATENCY-1] && !flush;
  assign pop       = out_valid && out_ready;
  assign inflight  = grng_popcount(32'(pipe_q));
  // Stored plus in-flight samples, crediting a pop happening this cycle.
  assign occupancy = 32'(level) + inflight - 32'(pop);
  assign gen_enable = (state_q == StRun) && !flush && (occupancy < DEPTH);

  // Warm-up counter and state transition.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    unique case (state_q)
      StWarmup: begin
        if (warm_q == WarmW'(WARMUP - 1)) begin
          state_d = StRun;
        end else begin
          warm_d = warm_q + 1'b1;
        end
      end
      StRun:    state_d = StRun;
      default:  state_d = StWarmup;
    endcase
  end

  // In-flight request shift register; flush forgets everything in the generator.
  always_comb begin
    pipe_d    = pipe_q << 1;
    pipe_d[0] = gen_enable;
    if (flush) begin
      pipe_d = '0;
    end
  end

  // State, warm-up counter and pipe registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StWarmup;
      warm_q  <= '0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      pipe_q  <= pipe_d;
    end
  end

  grng_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (flush),
    .push      (push),
    .push_data (gen_sample),
    .pop       (pop),
    .head_valid(out_valid),
    .head_data (out_data),
    .count     (level)
  );

endmodule

// File: tb/tb_grng_sample_buffer.sv
// Scoreboard bench for grng_sample_buffer with a generator model and random traffic.
module tb_grng_sample_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 2;
  localparam int unsigned WARM  = 5;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        gen_enable;
  logic [31:0] gen_sample = '0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  level;

  always #5 clk = ~clk;

  grng_sample_buffer #(
    .DEPTH      (DEPTH),
    .GEN_LATENCY(LAT),
    .WARMUP     (WARM)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .gen_enable(gen_enable),
    .gen_sample(gen_sample),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: samples requested but not yet due, and samples that should be stored.
  typedef struct {
    logic [31:0] val;
    int          due;
  } pend_t;

  pend_t       pending[$];
  logic [31:0] expq[$];
  int          cyc      = 0;
  int          warm_cnt = 0;

  // Generator model plus reference bookkeeping, acting on last cycle's observations.
  initial begin : model
    logic        s_en, s_flush, s_rstn;
    logic [31:0] stage_val [LAT];
    logic        stage_vld [LAT];
    logic [31:0] newval;
    for (int i = 0; i < LAT; i++) begin
      stage_val[i] = '0;
      stage_vld[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      s_en    = gen_enable;
      s_flush = flush;
      s_rstn  = resetn;
      @(posedge clk);
      #1;
      newval = {16'($urandom), 16'h0000};
      for (int i = LAT - 1; i > 0; i--) begin
        stage_val[i] = stage_val[i-1];
        stage_vld[i] = stage_vld[i-1];
      end
      stage_val[0] = newval;
      stage_vld[0] = s_en;
      // Outside a valid slot the generator output is junk the buffer must ignore.
      gen_sample = stage_vld[LAT-1] ? stage_val[LAT-1] : $urandom;
      if (!s_rstn || s_flush) begin
        pending.delete();
        expq.delete();
      end else begin
        if (pending.size() > 0 && pending[0].due == cyc) begin
          expq.push_back(pending[0].val);
          void'(pending.pop_front());
        end
        if (s_en) pending.push_back('{val: newval, due: cyc + LAT});
      end
      warm_cnt = s_rstn ? warm_cnt + 1 : 0;
      if (warm_cnt > 1000) warm_cnt = 1000;
      cyc++;
    end
  end

  // Monitor: compares outputs against the reference every cycle, pops on handshake.
  initial begin : monitor
    int  sum;
    bit  pop_exp;
    bit  en_exp;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        check("rst_gen_enable", gen_enable, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_out_data", out_data, 0);
      end else begin
        pop_exp = (expq.size() > 0) && out_ready;
        sum     = expq.size() + pending.size() - (pop_exp ? 1 : 0);
        en_exp  = (warm_cnt >= WARM) && !flush && (sum < DEPTH);
        check("issue_rule", gen_enable, en_exp);
        check("level", level, expq.size());
        check("out_valid", out_valid, expq.size() > 0);
        check("no_overflow", expq.size() <= DEPTH, 1);
        if (expq.size() > 0) begin
          check("out_data", out_data, expq[0]);
          if (out_ready) void'(expq.pop_front());
        end
      end
    end
  end

  // Directed scenarios followed by random traffic.
  initial begin : stim
    int n_en;
    resetn    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();

    // Release reset; this cycle is cycle 0. Fill with out_ready low.
    resetn = 1'b1;
    n_en   = 0;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k <= 5) check("warmup_enable", gen_enable, k == 5);
      if (k <= 9) check("first_valid", out_valid, k >= 8);
      n_en += int'(gen_enable);
      tick();
    end
    check("fill_enable_count", n_en, 4);
    check("fill_level", level, 4);
    check("fill_no_issue", gen_enable, 0);

    // One-cycle ready pulse at full level.
    out_ready = 1'b1;
    @(negedge clk);
    check("pulse_issue", gen_enable, 1);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("pulse_level_t1", level, 3);
    tick();
    tick();
    @(negedge clk);
    check("pulse_level_t3", level, 4);
    tick();

    // Sustained drain: one sample per cycle, continuous issue, level settles at 2.
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check("drain_enable", gen_enable, 1);
      check("drain_valid", out_valid, 1);
      if (k >= 2) check("drain_level", level, 2);
      tick();
    end

    // Flush with samples stored and two in flight.
    flush = 1'b1;
    @(negedge clk);
    check("flush_no_issue", gen_enable, 0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_level", level, 0);
    check("flush_valid", out_valid, 0);
    check("flush_resume", gen_enable, 1);
    tick();
    repeat (12) tick();

    // Asynchronous reset in the middle of a drain.
    resetn = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_enable", gen_enable, 0);
    check("async_rst_level", level, 0);
    check("async_rst_data", out_data, 0);
    tick();
    tick();
    resetn = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      check("rewarm_enable", gen_enable, k == 5);
      tick();
    end

    // Random backpressure and occasional flushes.
    for (int k = 0; k < 400; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
